spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Byte-level command sequencer that sits upstream of the SPI master byte engine.
//  Turns one command descriptor (opcode, optional address, optional dummy, N data bytes) into a TX byte stream.
//  Consumes the matching RX byte stream and returns read-data bytes.
//  Holds chip select across the whole command. Typical use: SPI flash/EEPROM access without CPU byte-banging.
// PARAMETERS
//  ADDR_BYTES  3   address bytes sent MSB first (1..4)
//  LEN_WIDTH   16  width of data-byte count
//  SLAVES      1   number of chip selects; SEL_W = (SLAVES>1) ? $clog2(SLAVES) : 1
// PORTS
//  clk_i           in   1              clock
//  rst_i           in   1              synchronous active-high reset
//  cmd_valid_i     in   1              descriptor valid
//  cmd_ready_o     out  1              descriptor accepted when valid&ready
//  cmd_opcode_i    in   8              command opcode
//  cmd_addr_en_i   in   1              1: send address phase
//  cmd_address_i   in   8*ADDR_BYTES   address
//  cmd_write_i     in   1              1: data bytes taken from wr stream; 0: read
//  cmd_length_i    in   LEN_WIDTH      data byte count (0 = none)
//  cmd_dummy_i     in   4              dummy byte count (used only with SPI_SEQ_DUMMY_EN)
//  cmd_slave_i     in   SEL_W          target slave index
//  wr_data_i       in   8              write byte
//  wr_valid_i      in   1              write byte valid
//  wr_ready_o      out  1              write byte consumed
//  rd_data_o       out  8              read byte
//  rd_valid_o      out  1              read byte valid, held until rd_ready_i
//  rd_ready_i      in   1              read byte consumer ready
//  tx_data_o       out  8              byte to SPI engine
//  tx_valid_o      out  1              byte valid
//  tx_ready_i      in   1              SPI engine accepts byte
//  rx_data_i       in   8              byte shifted in by SPI engine
//  rx_valid_i      in   1              one-cycle pulse, one per accepted TX byte
//  slave_select_o  out  SLAVES         one-hot active-high select, registered at accept
//  cs_hold_o       out  1              keep CS asserted between bytes
//  busy_o          out  1              state != IDLE
//  done_o          out  1              one-cycle pulse at command end
// BEHAVIOUR
//  - Reset (rst_i sampled high at posedge): state IDLE.
//    All outputs 0 except cmd_ready_o=1. Counters cleared. In-flight RX dropped. Reset has priority at every state.
//  - States: IDLE, SEND, WAIT_RX, DELIVER, DONE. Phase register: OPC, ADDR, DUMMY, DATA.
//  - IDLE: cmd_ready_o=1. On accept: latch descriptor, slave_select_o<=onehot(cmd_slave_i), cs_hold_o<=1, phase=OPC -> SEND.
//  - SEND: tx_valid_o=1 with byte per phase.
//    - OPC: opcode.
//    - ADDR: address byte, MSB first.
//    - DUMMY: 0xFF.
//    - DATA: wr_data_i (write) or 0x00 (read).
//    - Write DATA: tx_valid_o=wr_valid_i and wr_ready_o=tx_ready_i, both only in SEND.
//    - On tx_valid_o&tx_ready_i -> WAIT_RX.
//  - Exactly one byte outstanding: no new tx_valid_o until its rx_valid_i has arrived.
//    rx_valid_i outside WAIT_RX is ignored, including in the same cycle as a TX handshake.
//  - WAIT_RX on rx_valid_i:
//    - read DATA phase: capture rx_data_i -> DELIVER.
//    - otherwise: discard the byte and advance the phase/counter.
//  - DELIVER: rd_valid_o=1, rd_data_o stable until rd_ready_i. Then advance.
//  - Phase advance:
//    - OPC -> ADDR if addr_en, else next.
//    - ADDR after ADDR_BYTES bytes.
//    - DUMMY after dummy count.
//    - DATA after length bytes.
//    - Empty phases are skipped in the same step.
//    - After the last phase -> DONE. Next state is SEND while bytes remain.
//  - DONE: done_o=1 for one cycle, cs_hold_o<=0, slave_select_o<='0 -> IDLE. cmd_ready_o=1 again the cycle after DONE.
//  - Length counter counts down at LEN_WIDTH; length 0 skips DATA. Max length 2^LEN_WIDTH-1, no wrap.
//  - cmd_slave_i >= SLAVES: slave_select_o='0; the command still runs.
//  - Latency: accept -> first tx_valid_o 1 cycle. Read rx_valid_i -> rd_valid_o 1 cycle.
// CONFIGURATION
//  SPI_SEQ_DUMMY_EN defined: DUMMY phase sends cmd_dummy_i bytes of 0xFF; their RX bytes are discarded.
//  SPI_SEQ_DUMMY_EN undefined: cmd_dummy_i ignored, DUMMY phase never entered, no dummy counter logic.
// TESTING
//  1 Read 0x03 addr_en=1 addr 0x123456 len 2, RX data AB,CD.
//    -> TX 03,12,34,56,00,00; rd AB then CD; cs_hold_o high throughout; one done_o pulse.
//  2 Write 0x02 addr 0x000010 len 3, wr 11,22,33.
//    -> TX 02,00,00,10,11,22,33; rd_valid_o never high; wr_ready_o pulses 3 times.
//  3 Opcode 0x06 addr_en=0 len 0.
//    -> single TX 06; done_o 1 cycle after its rx_valid_i; busy_o low after.
//  4 Read len 2 with rd_ready_i low 10 cycles on byte 1.
//    -> rd_valid_o/rd_data_o held stable; no tx_valid_o until consumed.
//  5 rst_i high during ADDR phase.
//    -> next cycle busy_o=0, cs_hold_o=0, tx_valid_o=0, cmd_ready_o=1; late rx_valid_i ignored.
//  6 With SPI_SEQ_DUMMY_EN: 0x0B addr 0x000000 dummy 1 len 1, RX data 5A.
//    -> TX 0B,00,00,00,FF,00; rd 5A only.
//    Without the macro: TX 0B,00,00,00,00.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: turns one SPI command descriptor (opcode, optional address,
// optional dummy bytes, N data bytes) into a TX byte stream for a byte-level SPI
// engine, consumes the matching RX stream and returns read-data bytes.
// Exactly one byte is outstanding at a time; chip select is held for the whole command.
// Optional feature macro: SPI_SEQ_DUMMY_EN (enables the dummy-byte phase).
module spi_cmd_sequencer #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_WIDTH  = 16,
  parameter int SLAVES     = 1,
  localparam int SEL_W     = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [7:0]              cmd_opcode_i,
  input  logic                    cmd_addr_en_i,
  input  logic [8*ADDR_BYTES-1:0] cmd_address_i,
  input  logic                    cmd_write_i,
  input  logic [LEN_WIDTH-1:0]    cmd_length_i,
  input  logic [3:0]              cmd_dummy_i,
  input  logic [SEL_W-1:0]        cmd_slave_i,
  input  logic [7:0]              wr_data_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic [7:0]              rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic [SLAVES-1:0]       slave_select_o,
  output logic                    cs_hold_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RX,
    S_DELIVER,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_OPC,
    PH_ADDR,
    PH_DUMMY,
    PH_DATA
  } phase_t;

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);

  state_t                  state_reg;
  phase_t                  phase_reg;
  logic [7:0]              opcode_reg;
  logic                    addr_en_reg;
  logic                    write_reg;
  logic [8*ADDR_BYTES-1:0] addr_sh_reg;
  logic [2:0]              addr_cnt_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [7:0]              rd_data_reg;
  logic [SLAVES-1:0]       sel_reg;
  logic                    cs_hold_reg;

  logic [SLAVES-1:0]       sel_onehot;
  logic                    dummy_pending;
  logic                    dummy_more;
  logic                    len_pending;
  logic                    read_data;
  logic                    advance;
  phase_t                  tail_phase;
  logic                    tail_last;
  phase_t                  adv_phase;
  logic                    adv_last;
  logic [7:0]              tx_byte;

`ifdef SPI_SEQ_DUMMY_EN
  logic [3:0] dummy_reg;

  assign dummy_pending = (dummy_reg != 4'd0);
  assign dummy_more    = (dummy_reg > 4'd1);
`else
  logic unused_dummy;

  assign unused_dummy  = ^cmd_dummy_i;
  assign dummy_pending = 1'b0;
  assign dummy_more    = 1'b0;
`endif

  // One-hot decode of the requested slave; out-of-range indices select nothing.
  for (genvar gi = 0; gi < SLAVES; gi++) begin : g_sel
    assign sel_onehot[gi] = (cmd_slave_i == SEL_W'(gi));
  end

  assign len_pending = (len_reg != '0);
  assign read_data   = (phase_reg == PH_DATA) && !write_reg;

  // A byte finished without producing read data, or read data was handed off.
  assign advance = ((state_reg == S_WAIT_RX) && rx_valid_i && !read_data) ||
                   ((state_reg == S_DELIVER) && rd_ready_i);

  // Next phase after the current byte completes; empty phases are skipped.
  always_comb begin
    tail_phase = PH_DATA;
    tail_last  = 1'b0;
    if (dummy_pending) begin
      tail_phase = PH_DUMMY;
    end else if (!len_pending) begin
      tail_last = 1'b1;
    end

    adv_phase = phase_reg;
    adv_last  = 1'b0;
    unique case (phase_reg)
      PH_OPC: begin
        if (addr_en_reg) begin
          adv_phase = PH_ADDR;
        end else begin
          adv_phase = tail_phase;
          adv_last  = tail_last;
        end
      end
      PH_ADDR: begin
        if (addr_cnt_reg != ADDR_LAST) begin
          adv_phase = PH_ADDR;
        end else begin
          adv_phase = tail_phase;
          adv_last  = tail_last;
        end
      end
      PH_DUMMY: begin
        if (dummy_more) begin
          adv_phase = PH_DUMMY;
        end else begin
          adv_phase = PH_DATA;
          adv_last  = !len_pending;
        end
      end
      PH_DATA: begin
        adv_phase = PH_DATA;
        adv_last  = (len_reg == LEN_WIDTH'(1));
      end
    endcase
  end

  // Byte presented to the SPI engine for the current phase.
  always_comb begin
    tx_byte = 8'h00;
    unique case (phase_reg)
      PH_OPC:   tx_byte = opcode_reg;
      PH_ADDR:  tx_byte = addr_sh_reg[8*ADDR_BYTES-1 -: 8];
      PH_DUMMY: tx_byte = 8'hFF;
      PH_DATA:  tx_byte = write_reg ? wr_data_i : 8'h00;
    endcase
  end

  assign tx_valid_o     = (state_reg == S_SEND) &&
                          !((phase_reg == PH_DATA) && write_reg && !wr_valid_i);
  assign tx_data_o      = (state_reg == S_SEND) ? tx_byte : 8'h00;
  assign wr_ready_o     = (state_reg == S_SEND) && (phase_reg == PH_DATA) &&
                          write_reg && tx_ready_i;
  assign cmd_ready_o    = (state_reg == S_IDLE);
  assign busy_o         = (state_reg != S_IDLE);
  assign done_o         = (state_reg == S_DONE);
  assign rd_valid_o     = (state_reg == S_DELIVER);
  assign rd_data_o      = rd_data_reg;
  assign slave_select_o = sel_reg;
  assign cs_hold_o      = cs_hold_reg;

  // Command FSM: descriptor latch, byte handshakes, phase/counter advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      phase_reg    <= PH_OPC;
      opcode_reg   <= 8'h00;
      addr_en_reg  <= 1'b0;
      write_reg    <= 1'b0;
      addr_sh_reg  <= '0;
      addr_cnt_reg <= 3'd0;
      len_reg      <= '0;
      rd_data_reg  <= 8'h00;
      sel_reg      <= '0;
      cs_hold_reg  <= 1'b0;
`ifdef SPI_SEQ_DUMMY_EN
      dummy_reg    <= 4'd0;
`endif
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (cmd_valid_i) begin
            opcode_reg   <= cmd_opcode_i;
            addr_en_reg  <= cmd_addr_en_i;
            write_reg    <= cmd_write_i;
            addr_sh_reg  <= cmd_address_i;
            addr_cnt_reg <= 3'd0;
            len_reg      <= cmd_length_i;
`ifdef SPI_SEQ_DUMMY_EN
            dummy_reg    <= cmd_dummy_i;
`endif
            sel_reg      <= sel_onehot;
            cs_hold_reg  <= 1'b1;
            phase_reg    <= PH_OPC;
            state_reg    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_valid_o && tx_ready_i) begin
            state_reg <= S_WAIT_RX;
          end
        end
        S_WAIT_RX: begin
          if (rx_valid_i && read_data) begin
            rd_data_reg <= rx_data_i;
            state_reg   <= S_DELIVER;
          end
        end
        S_DELIVER: begin
        end
        S_DONE: begin
          cs_hold_reg <= 1'b0;
          sel_reg     <= '0;
          state_reg   <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      if (advance) begin
        phase_reg <= adv_phase;
        state_reg <= adv_last ? S_DONE : S_SEND;
        unique case (phase_reg)
          PH_ADDR: begin
            addr_cnt_reg <= addr_cnt_reg + 3'd1;
            addr_sh_reg  <= addr_sh_reg << 8;
          end
          PH_DUMMY: begin
`ifdef SPI_SEQ_DUMMY_EN
            dummy_reg <= dummy_reg - 4'd1;
`endif
          end
          PH_DATA: begin
            len_reg <= len_reg - LEN_WIDTH'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Testbench for spi_cmd_sequencer: directed and randomized commands against a
// byte-list reference model; the bench plays SPI engine, write source and read sink.
module tb_spi_cmd_sequencer;

  localparam int AB = 3;
  localparam int LW = 16;
  localparam int NS = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_opcode;
  logic          cmd_addr_en;
  logic [8*AB-1:0] cmd_address;
  logic          cmd_write;
  logic [LW-1:0] cmd_length;
  logic [3:0]    cmd_dummy;
  logic [SW-1:0] cmd_slave;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NS-1:0] slave_select;
  logic          cs_hold;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cmd_no = 0;

  spi_cmd_sequencer #(.ADDR_BYTES(AB), .LEN_WIDTH(LW), .SLAVES(NS)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_addr_en_i(cmd_addr_en),
    .cmd_address_i(cmd_address), .cmd_write_i(cmd_write),
    .cmd_length_i(cmd_length), .cmd_dummy_i(cmd_dummy), .cmd_slave_i(cmd_slave),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .slave_select_o(slave_select), .cs_hold_o(cs_hold),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cmd %0d)", tag, got, exp, cmd_no);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cmd_ready"}, cmd_ready, 1);
    check_val({tag, "_cs_hold"}, cs_hold, 0);
    check_val({tag, "_sel"}, slave_select, 0);
    check_val({tag, "_tx_valid"}, tx_valid, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  // Run one command; expectations come from the byte-list model built up front.
  task automatic run_cmd(input logic [7:0] opc, input logic aen, input logic [23:0] addr,
                         input logic wr, input int len, input logic [3:0] dmy,
                         input logic [1:0] slv, input int stall);
    logic [7:0] exp_tx[$];
    logic [7:0] wr_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] b;
    logic [NS-1:0] exp_sel;
    int hdr, tx_idx, wr_idx, rd_cnt, done_cnt, rx_wait, stall_left;
    bit pending, pend_rd, rx_real, prev_rd_rx, exp_done;

    exp_tx.push_back(opc);
    if (aen) for (int i = AB - 1; i >= 0; i--) exp_tx.push_back(addr[8*i +: 8]);
`ifdef SPI_SEQ_DUMMY_EN
    for (int i = 0; i < int'(dmy); i++) exp_tx.push_back(8'hFF);
`endif
    hdr = exp_tx.size();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (wr) begin
        wr_q.push_back(b);
        exp_tx.push_back(b);
      end else begin
        exp_tx.push_back(8'h00);
      end
    end
    exp_sel = (int'(slv) < NS) ? NS'(1 << slv) : '0;
    tx_idx = 0; wr_idx = 0; rd_cnt = 0; done_cnt = 0; rx_wait = 0;
    pending = 0; pend_rd = 0; prev_rd_rx = 0; exp_done = 0;
    stall_left = stall;

    @(negedge clk);
    idle_inputs();
    cmd_opcode  = opc;
    cmd_addr_en = aen;
    cmd_address = addr;
    cmd_write   = wr;
    cmd_length  = LW'(len);
    cmd_dummy   = dmy;
    cmd_slave   = slv;
    cmd_valid   = 1'b1;
    #1 check_val("cmd_ready", cmd_ready, 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rx_real   = 0;
      rx_data   = 8'($urandom);
      if (pending && rx_wait == 0) begin
        rx_valid = 1'b1;
        rx_real  = 1;
      end else begin
        if (pending) rx_wait--;
        rx_valid = !pending && ($urandom % 6 == 0);
      end
      tx_ready = ($urandom % 4) != 0;
      wr_valid = ($urandom % 3) != 0;
      wr_data  = (wr_idx < wr_q.size()) ? wr_q[wr_idx] : 8'($urandom);
      if (rd_valid && stall_left > 0) begin
        rd_ready = 1'b0;
        stall_left--;
      end else begin
        rd_ready = ($urandom % 3) != 0;
      end
      #1;
      if (cyc == 0) check_val("first_tx_latency", tx_valid, 1);
      if (prev_rd_rx) check_val("rd_latency", rd_valid, 1);
      prev_rd_rx = 0;
      check_val("done", done, exp_done);
      exp_done = 0;
      check_val("cs_hold", cs_hold, 1);
      check_val("sel", slave_select, exp_sel);
      check_val("busy", busy, 1);
      if (tx_valid) begin
        check_val("one_outstanding", pending, 0);
        check_val("tx_while_rd", rd_valid, 0);
        if (tx_ready) begin
          if (tx_idx < exp_tx.size()) check_val("tx_byte", tx_data, exp_tx[tx_idx]);
          else check_val("tx_extra", tx_idx, exp_tx.size());
          pend_rd = !wr && (tx_idx >= hdr);
          tx_idx++;
          pending = 1;
          rx_wait = $urandom % 3;
        end
      end
      if (wr_ready && wr_valid) begin
        check_val("wr_hs_is_tx_hs", tx_valid && tx_ready, 1);
        wr_idx++;
      end
      if (rx_real) begin
        pending = 0;
        if (pend_rd) begin
          exp_rd.push_back(rx_data);
          prev_rd_rx = 1;
        end else if (tx_idx == exp_tx.size()) begin
          exp_done = 1;
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() > 0) check_val("rd_data", rd_data, exp_rd[0]);
        else check_val("rd_spurious", rd_valid, 0);
        if (rd_ready && exp_rd.size() > 0) begin
          void'(exp_rd.pop_front());
          rd_cnt++;
          if (rd_cnt == len && tx_idx == exp_tx.size()) exp_done = 1;
        end
      end
      if (done) begin
        done_cnt++;
        break;
      end
    end

    check_val("done_seen", done_cnt, 1);
    check_val("tx_count", tx_idx, exp_tx.size());
    check_val("rd_count", rd_cnt, wr ? 0 : len);
    check_val("wr_count", wr_idx, wr ? len : 0);
    @(negedge clk);
    idle_inputs();
    #1 check_idle("post");
    $display("cmd %0d op=%02h aen=%0d addr=%06h wr=%0d len=%0d dummy=%0d slave=%0d tx=%0d rd=%0d wr=%0d",
             cmd_no, opc, aen, addr, wr, len, dmy, slv, tx_idx, rd_cnt, wr_idx);
    cmd_no++;
  endtask

  // Reset asserted while the address phase is in flight; a late RX pulse must be ignored.
  task automatic reset_mid_addr();
    @(negedge clk);
    idle_inputs();
    cmd_opcode  = 8'h03;
    cmd_addr_en = 1'b1;
    cmd_address = 24'h123456;
    cmd_write   = 1'b0;
    cmd_length  = LW'(2);
    cmd_dummy   = 4'd0;
    cmd_slave   = 2'd1;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    tx_ready  = 1'b1;
    #1 check_val("r5_opcode", tx_data, 8'h03);
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    #1 check_val("r5_addr_byte", tx_data, 8'h12);
    @(negedge clk);
    tx_ready = 1'b0;
    rst      = 1'b1;
    #1 check_val("r5_busy_before", busy, 1);
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #1 check_idle("r5_after_reset");
    @(negedge clk);
    rx_valid = 1'b0;
    #1 check_idle("r5_late_rx");
    $display("cmd %0d reset during address phase", cmd_no);
    cmd_no++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cmd_opcode = 8'h00; cmd_addr_en = 1'b0; cmd_address = '0; cmd_write = 1'b0;
    cmd_length = '0; cmd_dummy = 4'd0; cmd_slave = '0;
    wr_data = 8'h00; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_idle("reset");
    check_val("reset_rd_data", rd_data, 0);
    check_val("reset_wr_ready", wr_ready, 0);

    run_cmd(8'h03, 1'b1, 24'h123456, 1'b0, 2, 4'd0, 2'd0, 0);
    run_cmd(8'h02, 1'b1, 24'h000010, 1'b1, 3, 4'd0, 2'd1, 0);
    run_cmd(8'h06, 1'b0, 24'h000000, 1'b0, 0, 4'd0, 2'd2, 0);
    run_cmd(8'h03, 1'b0, 24'h000000, 1'b0, 2, 4'd0, 2'd0, 10);
    reset_mid_addr();
    run_cmd(8'h0B, 1'b1, 24'h000000, 1'b0, 1, 4'd1, 2'd0, 0);
    run_cmd(8'h9F, 1'b0, 24'h000000, 1'b0, 3, 4'd0, 2'd3, 0);

    for (int n = 0; n < 40; n++) begin
      run_cmd(8'($urandom), 1'($urandom), 24'($urandom), 1'($urandom),
              int'($urandom % 6), 4'($urandom % 3), 2'($urandom % 4),
              ($urandom % 4 == 0) ? int'($urandom % 6) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
